// File: rtl/msg_fifo_ctrl_if.sv
// -----------------------------------------------------------------------------
// msg_fifo_ctrl_if
// Purpose : groups the strobe inputs and the registered status outputs of the
//           message FIFO controller into one bundle.
// Signals :
//   flush, b_next, a_next         -- strobes from the client to the controller
//   b_ptr, a_ptr, fill_count      -- slot pointers and committed-message count
//   not_empty, full               -- level flags
//   overflow, rd_err, ptr_err     -- one-cycle event pulses
// Modports:
//   master -- client side (drives strobes, observes status)
//   slave  -- controller side (msg_fifo_ctrl)
// -----------------------------------------------------------------------------
interface msg_fifo_ctrl_if #(
  parameter int PTR_W = 2
) ();
  logic             flush;
  logic             b_next;
  logic             a_next;
  logic [PTR_W-1:0] b_ptr;
  logic [PTR_W-1:0] a_ptr;
  logic [PTR_W-1:0] fill_count;
  logic             not_empty;
  logic             full;
  logic             overflow;
  logic             rd_err;
  logic             ptr_err;

  modport master (
    output flush, b_next, a_next,
    input  b_ptr, a_ptr, fill_count, not_empty, full, overflow, rd_err, ptr_err
  );

  modport slave (
    input  flush, b_next, a_next,
    output b_ptr, a_ptr, fill_count, not_empty, full, overflow, rd_err, ptr_err
  );
endinterface

// File: rtl/msg_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// msg_fifo_ctrl
// Purpose : pointer/count controller for a ring of DEPTH message slots. The
//           writer fills slot b_ptr and commits it with b_next; the reader
//           consumes slot a_ptr and releases it with a_next. At most DEPTH-1
//           messages are held so the slot being written never aliases a stored
//           message. All outputs are registered.
// Ports   :
//   clk    -- single clock, rising edge
//   reset  -- synchronous active-high reset
//   bus    -- msg_fifo_ctrl_if.slave (strobes in, status/pulses out)
// Parameters:
//   DEPTH      -- number of slots (power of two, 2..16)
//   PTR_W      -- log2(DEPTH)
//   WARN_LEVEL -- fill level at and above which full asserts
//   OVWR       -- 0: drop newest on overflow, 1: overwrite oldest
// Optional feature:
//   MSG_FIFO_CONSISTENCY_CHECK_EN -- when defined, checks every cycle that
//   (b_ptr - a_ptr) mod DEPTH equals fill_count; on mismatch the controller
//   resynchronises to the empty state and pulses ptr_err and overflow.
//   When undefined, ptr_err is tied low.
// -----------------------------------------------------------------------------
module msg_fifo_ctrl #(
  parameter int DEPTH      = 4,
  parameter int PTR_W      = 2,
  parameter int WARN_LEVEL = 3,
  parameter int OVWR       = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  msg_fifo_ctrl_if.slave       bus
);

  localparam logic [PTR_W-1:0] MAX_FILL = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W:0]   WARN_EXT = (PTR_W + 1)'(WARN_LEVEL);
  localparam logic [PTR_W-1:0] ONE      = PTR_W'(1);

  logic [PTR_W-1:0] a_ptr_q, a_ptr_d;
  logic [PTR_W-1:0] b_ptr_q, b_ptr_d;
  logic [PTR_W-1:0] fill_q, fill_d;
  logic             not_empty_q, not_empty_d;
  logic             full_q, full_d;
  logic             overflow_q, overflow_d;
  logic             rd_err_q, rd_err_d;
  logic             mismatch;

`ifdef MSG_FIFO_CONSISTENCY_CHECK_EN
  logic             ptr_err_q;
  // Pointer difference wraps naturally because DEPTH == 2**PTR_W.
  assign mismatch    = ((b_ptr_q - a_ptr_q) != fill_q);
  assign bus.ptr_err = ptr_err_q;
`else
  assign mismatch    = 1'b0;
  assign bus.ptr_err = 1'b0;
`endif

  always_comb begin
    a_ptr_d    = a_ptr_q;
    b_ptr_d    = b_ptr_q;
    fill_d     = fill_q;
    overflow_d = 1'b0;
    rd_err_d   = 1'b0;

    if (mismatch) begin
      // Corrupted bookkeeping: drop everything and restart empty.
      a_ptr_d    = '0;
      b_ptr_d    = '0;
      fill_d     = '0;
      overflow_d = 1'b1;
    end else if (bus.flush) begin
      a_ptr_d = b_ptr_q;
      fill_d  = '0;
    end else begin
      unique case ({bus.a_next, bus.b_next})
        2'b11: begin
          b_ptr_d = b_ptr_q + ONE;
          // When empty there is nothing to release yet; only the commit lands.
          if (fill_q != '0) a_ptr_d = a_ptr_q + ONE;
          else              fill_d  = ONE;
        end
        2'b01: begin
          if (fill_q != MAX_FILL) begin
            b_ptr_d = b_ptr_q + ONE;
            fill_d  = fill_q + ONE;
          end else begin
            overflow_d = 1'b1;
            if (OVWR != 0) begin
              a_ptr_d = a_ptr_q + ONE;
              b_ptr_d = b_ptr_q + ONE;
            end
          end
        end
        2'b10: begin
          if (fill_q != '0) begin
            a_ptr_d = a_ptr_q + ONE;
            fill_d  = fill_q - ONE;
          end else begin
            rd_err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Flags track the next count so they move on the same edge as fill_count.
    not_empty_d = (fill_d != '0);
    full_d      = ({1'b0, fill_d} >= WARN_EXT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_ptr_q     <= '0;
      b_ptr_q     <= '0;
      fill_q      <= '0;
      not_empty_q <= 1'b0;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      rd_err_q    <= 1'b0;
    end else begin
      a_ptr_q     <= a_ptr_d;
      b_ptr_q     <= b_ptr_d;
      fill_q      <= fill_d;
      not_empty_q <= not_empty_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      rd_err_q    <= rd_err_d;
    end
  end

`ifdef MSG_FIFO_CONSISTENCY_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) ptr_err_q <= 1'b0;
    else       ptr_err_q <= mismatch;
  end
`endif

  assign bus.a_ptr      = a_ptr_q;
  assign bus.b_ptr      = b_ptr_q;
  assign bus.fill_count = fill_q;
  assign bus.not_empty  = not_empty_q;
  assign bus.full       = full_q;
  assign bus.overflow   = overflow_q;
  assign bus.rd_err     = rd_err_q;

endmodule

// File: tb/tb_msg_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_msg_fifo_ctrl
// Two controllers (drop-newest and overwrite-oldest) share one stimulus stream.
// A reference model holds the oldest-slot index and the message count per
// controller; the write slot is derived as (oldest + count) mod DEPTH.
// -----------------------------------------------------------------------------
module tb_msg_fifo_ctrl;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
  localparam int WARN  = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  msg_fifo_ctrl_if #(.PTR_W(PTR_W)) if0 ();
  msg_fifo_ctrl_if #(.PTR_W(PTR_W)) if1 ();

  msg_fifo_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W), .WARN_LEVEL(WARN), .OVWR(0)) dut0 (
    .clk(clk), .reset(reset), .bus(if0.slave));
  msg_fifo_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W), .WARN_LEVEL(WARN), .OVWR(1)) dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave));

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state per controller
  int  m_a   [2];
  int  m_cnt [2];
  int  m_ovf [2];
  int  m_rde [2];
  bit  m_valid = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_step(input bit r, input bit f, input bit an, input bit bn);
    for (int k = 0; k < 2; k++) begin
      m_ovf[k] = 0;
      m_rde[k] = 0;
      if (r) begin
        m_a[k] = 0; m_cnt[k] = 0;
      end else if (f) begin
        m_a[k] = (m_a[k] + m_cnt[k]) % DEPTH;
        m_cnt[k] = 0;
      end else if (an && bn) begin
        if (m_cnt[k] > 0) m_a[k] = (m_a[k] + 1) % DEPTH;
        else              m_cnt[k] = 1;
      end else if (bn) begin
        if (m_cnt[k] < DEPTH - 1) m_cnt[k]++;
        else begin
          m_ovf[k] = 1;
          if (k == 1) m_a[k] = (m_a[k] + 1) % DEPTH;
        end
      end else if (an) begin
        if (m_cnt[k] > 0) begin
          m_a[k] = (m_a[k] + 1) % DEPTH;
          m_cnt[k]--;
        end else m_rde[k] = 1;
      end
    end
    if (r) m_valid = 1'b1;
  endtask

  task automatic drive(input bit r, input bit f, input bit an, input bit bn);
    reset = r;
    if0.flush = f; if0.a_next = an; if0.b_next = bn;
    if1.flush = f; if1.a_next = an; if1.b_next = bn;
    @(posedge clk);
    model_step(r, f, an, bn);
    #1;
  endtask

  task automatic cmp_dut(input int k, input int ap, input int bp, input int fc,
                         input int ne, input int fu, input int ov, input int re,
                         input int pe);
    string p;
    p = (k == 0) ? "drop" : "ovwr";
    chk({p, ".a_ptr"},      ap, m_a[k]);
    chk({p, ".b_ptr"},      bp, (m_a[k] + m_cnt[k]) % DEPTH);
    chk({p, ".fill_count"}, fc, m_cnt[k]);
    chk({p, ".not_empty"},  ne, int'(m_cnt[k] != 0));
    chk({p, ".full"},       fu, int'(m_cnt[k] >= WARN));
    chk({p, ".overflow"},   ov, m_ovf[k]);
    chk({p, ".rd_err"},     re, m_rde[k]);
    chk({p, ".ptr_err"},    pe, 0);
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      cmp_dut(0, int'(if0.a_ptr), int'(if0.b_ptr), int'(if0.fill_count),
              int'(if0.not_empty), int'(if0.full), int'(if0.overflow),
              int'(if0.rd_err), int'(if0.ptr_err));
      cmp_dut(1, int'(if1.a_ptr), int'(if1.b_ptr), int'(if1.fill_count),
              int'(if1.not_empty), int'(if1.full), int'(if1.overflow),
              int'(if1.rd_err), int'(if1.ptr_err));
    end
  end

  initial begin
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);

    // Reset state
    chk("rst.a_ptr", int'(if0.a_ptr), 0);
    chk("rst.fill",  int'(if0.fill_count), 0);
    $display("reset: a=%0d b=%0d fill=%0d", if0.a_ptr, if0.b_ptr, if0.fill_count);

    // Four single commits
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 0, 1);
      $display("commit %0d: drop fill=%0d b=%0d ovf=%0d | ovwr a=%0d b=%0d ovf=%0d",
               i, if0.fill_count, if0.b_ptr, if0.overflow, if1.a_ptr, if1.b_ptr, if1.overflow);
      if (i == 3) begin
        chk("c3.fill", int'(if0.fill_count), 3);
        chk("c3.full", int'(if0.full), 1);
        chk("c3.b_ptr", int'(if0.b_ptr), 3);
      end
      if (i == 4) begin
        chk("c4.drop.ovf",  int'(if0.overflow), 1);
        chk("c4.drop.fill", int'(if0.fill_count), 3);
        chk("c4.drop.b",    int'(if0.b_ptr), 3);
        chk("c4.ovwr.a",    int'(if1.a_ptr), 1);
        chk("c4.ovwr.b",    int'(if1.b_ptr), 0);
        chk("c4.ovwr.fill", int'(if1.fill_count), 3);
        chk("c4.ovwr.ovf",  int'(if1.overflow), 1);
      end
    end
    drive(0, 0, 0, 0);
    chk("c5.ovf_low", int'(if0.overflow), 0);
    chk("c5.ovwr_ovf_low", int'(if1.overflow), 0);

    // Simultaneous strobes at fill=2 and at fill=0
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    drive(0, 0, 1, 1);
    $display("both@2: a=%0d b=%0d fill=%0d", if0.a_ptr, if0.b_ptr, if0.fill_count);
    chk("both2.fill", int'(if0.fill_count), 2);
    chk("both2.a", int'(if0.a_ptr), 1);
    chk("both2.b", int'(if0.b_ptr), 3);
    drive(1, 0, 0, 0);
    drive(0, 0, 1, 1);
    $display("both@0: a=%0d b=%0d fill=%0d rd_err=%0d", if0.a_ptr, if0.b_ptr, if0.fill_count, if0.rd_err);
    chk("both0.fill", int'(if0.fill_count), 1);
    chk("both0.a", int'(if0.a_ptr), 0);
    chk("both0.rd_err", int'(if0.rd_err), 0);

    // Read while empty, then flush with a concurrent commit
    drive(1, 0, 0, 0);
    drive(0, 0, 1, 0);
    $display("rd_empty: rd_err=%0d fill=%0d", if0.rd_err, if0.fill_count);
    chk("rde.pulse", int'(if0.rd_err), 1);
    chk("rde.a", int'(if0.a_ptr), 0);
    drive(0, 0, 0, 0);
    chk("rde.low", int'(if0.rd_err), 0);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    drive(0, 1, 0, 1);
    $display("flush: a=%0d b=%0d fill=%0d ne=%0d", if0.a_ptr, if0.b_ptr, if0.fill_count, if0.not_empty);
    chk("flush.a", int'(if0.a_ptr), 2);
    chk("flush.b", int'(if0.b_ptr), 2);
    chk("flush.fill", int'(if0.fill_count), 0);
    chk("flush.ne", int'(if0.not_empty), 0);

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 600; i++) begin
      bit f, an, bn, r;
      r  = ($urandom_range(0, 59) == 0);
      f  = ($urandom_range(0, 15) == 0);
      bn = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 40));
      an = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 60));
      drive(r, f, an, bn);
      $display("rnd %0d: r=%0d f=%0d a=%0d b=%0d -> a_ptr=%0d b_ptr=%0d fill=%0d ovf=%0d/%0d rde=%0d",
               i, r, f, an, bn, if0.a_ptr, if0.b_ptr, if0.fill_count,
               if0.overflow, if1.overflow, if0.rd_err);
    end

    // Reset after traffic
    drive(0, 0, 0, 1);
    drive(1, 1, 1, 1);
    $display("reset after traffic: a=%0d b=%0d fill=%0d", if1.a_ptr, if1.b_ptr, if1.fill_count);
    chk("rst2.a", int'(if1.a_ptr), 0);
    chk("rst2.b", int'(if1.b_ptr), 0);
    chk("rst2.fill", int'(if1.fill_count), 0);
    chk("rst2.flags", int'({if1.not_empty, if1.full, if1.overflow, if1.rd_err}), 0);

`ifdef MSG_FIFO_CONSISTENCY_CHECK_EN
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    m_valid = 1'b0;
    force dut0.fill_q = 2'd1;
    @(negedge clk);
    release dut0.fill_q;
    drive(0, 0, 0, 1);
    $display("consistency: ptr_err=%0d ovf=%0d a=%0d b=%0d fill=%0d",
             if0.ptr_err, if0.overflow, if0.a_ptr, if0.b_ptr, if0.fill_count);
    chk("cc.ptr_err", int'(if0.ptr_err), 1);
    chk("cc.ovf", int'(if0.overflow), 1);
    chk("cc.ptrs", int'({if0.a_ptr, if0.b_ptr, if0.fill_count}), 0);
    drive(1, 0, 0, 0);
`endif

    drive(0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
